// File: rtl/laser_point_host.sv
// Host end of the LASER point-stream link: holds a 40-point pattern, streams it out,
// waits for the solver's centers, then counts the points covered by either center.
module laser_point_host #(
    parameter int NPTS    = 40,
    parameter int R_SQ    = 16,
    parameter int TMO_CYC = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LD_EN,
    input  logic [5:0] LD_ADDR,
    input  logic [3:0] LD_X,
    input  logic [3:0] LD_Y,
    input  logic       START,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic       STRB,
    input  logic       DONE,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic       BUSY,
    output logic       RES_VLD,
    output logic [5:0] SCORE,
    output logic       TMO,
    output logic [2:0] STATE_DBG
);

    // Handshake: STRB qualifies X/Y for exactly one cycle per point, no back-pressure;
    // DONE qualifies C1X..C2Y in its own cycle; RES_VLD qualifies SCORE/TMO for one cycle.

    localparam int WW = $clog2(TMO_CYC);
    localparam logic [5:0]    IDX_LAST  = 6'(NPTS - 1);
    localparam logic [WW-1:0] WCNT_LAST = WW'(TMO_CYC - 1);
    localparam logic [8:0]    RSQ       = 9'(R_SQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_WAIT   = 3'd2,
        S_SCORE  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      mem [NPTS];
    logic [5:0]      idx;
    logic [WW-1:0]   wcnt;
    logic [5:0]      acc;
    logic [5:0]      score_q;
    logic            tmo_q;
    logic [3:0]      c1x_q, c1y_q, c2x_q, c2y_q;
    logic [3:0]      px, py;
    logic            covered;

    function automatic logic [8:0] dist_sq(input logic [3:0] ax, input logic [3:0] ay,
                                           input logic [3:0] bx, input logic [3:0] by);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        dx = (ax >= bx) ? ax - bx : bx - ax;
        dy = (ay >= by) ? ay - by : by - ay;
        sx = {4'd0, dx} * {4'd0, dx};
        sy = {4'd0, dy} * {4'd0, dy};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    // One read port serves both the stream and the scoring pass.
    assign {px, py} = mem[idx];
    assign covered  = (dist_sq(px, py, c1x_q, c1y_q) <= RSQ) ||
                      (dist_sq(px, py, c2x_q, c2y_q) <= RSQ);

    // Pattern RAM has no reset so a reload is not needed after an aborted run.
    always_ff @(posedge CLK) begin
        if (RST && state == S_IDLE && LD_EN && LD_ADDR <= IDX_LAST) begin
            mem[LD_ADDR] <= {LD_X, LD_Y};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= S_IDLE;
            idx     <= '0;
            wcnt    <= '0;
            acc     <= '0;
            score_q <= '0;
            tmo_q   <= 1'b0;
            c1x_q   <= '0;
            c1y_q   <= '0;
            c2x_q   <= '0;
            c2y_q   <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    idx  <= '0;
                    wcnt <= '0;
                end
                S_STREAM: begin
                    idx <= (idx == IDX_LAST) ? 6'd0 : idx + 6'd1;
                end
                S_WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    if (DONE) begin
                        c1x_q <= C1X;
                        c1y_q <= C1Y;
                        c2x_q <= C2X;
                        c2y_q <= C2Y;
                        idx   <= '0;
                        acc   <= '0;
                    end else if (wcnt == WCNT_LAST) begin
                        tmo_q   <= 1'b1;
                        score_q <= '0;
                    end
                end
                S_SCORE: begin
                    acc <= acc + 6'(covered);
                    idx <= (idx == IDX_LAST) ? 6'd0 : idx + 6'd1;
                    if (idx == IDX_LAST) begin
                        score_q <= acc + 6'(covered);
                        tmo_q   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        X        = '0;
        Y        = '0;
        STRB     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (START) state_nx = S_STREAM;
            end
            S_STREAM: begin
                X    = px;
                Y    = py;
                STRB = 1'b1;
                if (idx == IDX_LAST) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (DONE) state_nx = S_SCORE;
                else if (wcnt == WCNT_LAST) state_nx = S_REPORT;
            end
            S_SCORE: begin
                if (idx == IDX_LAST) state_nx = S_REPORT;
            end
            S_REPORT: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign BUSY      = (state != S_IDLE);
    assign RES_VLD   = (state == S_REPORT);
    assign SCORE     = score_q;
    assign TMO       = tmo_q;
    assign STATE_DBG = state;

endmodule

// File: tb/tb_laser_point_host.sv
// Bench for laser_point_host: timestamp-based run model with a stream queue, checked every
// cycle, plus directed scenarios with hand-computed scores and latencies.
module tb_laser_point_host;

    localparam int NPTS    = 40;
    localparam int R_SQ    = 16;
    localparam int TMO_CYC = 4096;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       LD_EN = 1'b0;
    logic [5:0] LD_ADDR = '0;
    logic [3:0] LD_X = '0, LD_Y = '0;
    logic       START = 1'b0;
    logic       DONE = 1'b0;
    logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
    logic [3:0] X, Y;
    logic       STRB, BUSY, RES_VLD, TMO;
    logic [5:0] SCORE;
    logic [2:0] STATE_DBG;

    laser_point_host #(.NPTS(NPTS), .R_SQ(R_SQ), .TMO_CYC(TMO_CYC)) dut (
        .CLK(CLK), .RST(RST), .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_X(LD_X), .LD_Y(LD_Y),
        .START(START), .X(X), .Y(Y), .STRB(STRB), .DONE(DONE),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .BUSY(BUSY), .RES_VLD(RES_VLD), .SCORE(SCORE), .TMO(TMO), .STATE_DBG(STATE_DBG)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- model state ----------------
    int         pat_x [NPTS];
    int         pat_y [NPTS];
    logic [7:0] exp_q [$];
    bit         run_on = 1'b0;
    int         run_at = 0;
    int         done_at = -1;
    int         pend_score = 0;
    int         exp_score = 0;
    bit         exp_tmo = 1'b0;
    bit         chk_en = 1'b0;

    bit         res_seen = 1'b0;
    int         res_cyc = 0;
    int         res_score = 0;
    bit         res_tmo = 1'b0;
    int         last_strb = 0;
    int         done_cyc = 0;

    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int model_score(input int c1x, input int c1y, input int c2x, input int c2y);
        int n;
        n = 0;
        for (int i = 0; i < NPTS; i++) begin
            int d1, d2;
            d1 = (pat_x[i] - c1x) * (pat_x[i] - c1x) + (pat_y[i] - c1y) * (pat_y[i] - c1y);
            d2 = (pat_x[i] - c2x) * (pat_x[i] - c2x) + (pat_y[i] - c2y) * (pat_y[i] - c2y);
            if (d1 <= R_SQ || d2 <= R_SQ) n++;
        end
        return n;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        int         res_at;
        bit         idle, in_stream, rv_e;
        logic [7:0] pt;
        if (chk_en) begin
            idle      = !run_on;
            res_at    = (done_at >= 0) ? done_at + NPTS + 1 : run_at + NPTS + TMO_CYC + 1;
            in_stream = run_on && cyc > run_at && cyc <= run_at + NPTS;
            rv_e      = run_on && cyc == res_at;
            if (rv_e) begin
                exp_tmo   = (done_at < 0);
                exp_score = (done_at < 0) ? 0 : pend_score;
            end
            if (in_stream) begin
                check("stream_q_nonempty", exp_q.size() > 0, 1);
                pt = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                check("x", X, pt[7:4]);
                check("y", Y, pt[3:0]);
            end else begin
                check("x_idle", X, 0);
                check("y_idle", Y, 0);
            end
            check("strb", STRB, in_stream);
            check("busy", BUSY, run_on);
            check("res_vld", RES_VLD, rv_e);
            check("score", SCORE, exp_score);
            check("tmo", TMO, exp_tmo);

            if (STRB === 1'b1) last_strb = cyc;
            if (RES_VLD === 1'b1) begin
                res_seen  = 1'b1;
                res_cyc   = cyc;
                res_score = SCORE;
                res_tmo   = TMO;
            end

            // inputs seen this cycle take effect from the next one
            if (RST !== 1'b1) begin
                run_on = 1'b0;
                exp_q.delete();
                exp_score = 0;
                exp_tmo   = 1'b0;
            end else if (idle) begin
                if (LD_EN && LD_ADDR < NPTS) begin
                    pat_x[LD_ADDR] = LD_X;
                    pat_y[LD_ADDR] = LD_Y;
                end
                if (START) begin
                    run_on  = 1'b1;
                    run_at  = cyc;
                    done_at = -1;
                    for (int i = 0; i < NPTS; i++) exp_q.push_back({4'(pat_x[i]), 4'(pat_y[i])});
                end
            end else if (rv_e) begin
                run_on = 1'b0;
            end else if (done_at < 0 && cyc > run_at + NPTS && DONE === 1'b1) begin
                done_at    = cyc;
                pend_score = model_score(C1X, C1Y, C2X, C2Y);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_pt(input int a, input int x, input int y);
        LD_EN   = 1'b1;
        LD_ADDR = 6'(a);
        LD_X    = 4'(x);
        LD_Y    = 4'(y);
        tick();
        LD_EN   = 1'b0;
    endtask

    task automatic start_run();
        res_seen = 1'b0;
        START    = 1'b1;
        tick();
        START    = 1'b0;
    endtask

    task automatic done_after(input int gap, input int c1x, input int c1y, input int c2x, input int c2y);
        repeat (gap) tick();
        DONE     = 1'b1;
        C1X      = 4'(c1x);
        C1Y      = 4'(c1y);
        C2X      = 4'(c2x);
        C2Y      = 4'(c2y);
        done_cyc = cyc;
        tick();
        DONE     = 1'b0;
        C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    endtask

    task automatic wait_res(input int budget, input string name);
        int k;
        k = 0;
        while (!res_seen && k < budget) begin
            tick();
            k++;
        end
        check({name, "_res_seen"}, res_seen, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        for (int i = 0; i < NPTS; i++) begin
            pat_x[i] = 0;
            pat_y[i] = 0;
        end
        RST = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_strb", STRB, 0);
        check("rst_busy", BUSY, 0);
        check("rst_res_vld", RES_VLD, 0);
        check("rst_score", SCORE, 0);
        check("rst_tmo", TMO, 0);
        RST = 1'b1;
        tick();

        // all points on C1 -> every point covered
        for (int i = 0; i < NPTS; i++) load_pt(i, 2, 2);
        start_run();
        done_after(41, 2, 2, 12, 12);
        wait_res(100, "s1");
        check("s1_score", res_score, 40);
        check("s1_tmo", res_tmo, 0);

        // radius boundary: 16 is inside, 18 is not; same-cycle load+START; dropped addresses
        for (int i = 2; i < NPTS; i++) load_pt(i, 15, 15);
        load_pt(40, 0, 0);
        load_pt(63, 0, 0);
        load_pt(0, 6, 2);
        LD_EN = 1'b1; LD_ADDR = 6'd1; LD_X = 4'd5; LD_Y = 4'd5;
        start_run();
        LD_EN = 1'b0;
        done_after(40, 2, 2, 0, 0);
        wait_res(100, "s2");
        check("s2_score", res_score, 1);
        check("s2_tmo", res_tmo, 0);

        // START mid-stream and LD_EN mid-WAIT are dropped
        start_run();
        repeat (9) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (32) tick();
        load_pt(2, 1, 1);
        done_after(0, 15, 15, 9, 9);
        wait_res(100, "s4");
        check("s4_score", res_score, 38);
        check("s4_tmo", res_tmo, 0);

        // DONE never arrives: 4096 WAIT cycles, then the timeout report
        start_run();
        wait_res(TMO_CYC + 200, "s3");
        check("s3_tmo", res_tmo, 1);
        check("s3_score", res_score, 0);
        check("s3_gap", res_cyc - last_strb, TMO_CYC + 1);

        // reset at stream index 20 aborts silently; a new run replays the whole pattern
        start_run();
        repeat (20) tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("s5_strb", STRB, 0);
        check("s5_busy", BUSY, 0);
        check("s5_score", SCORE, 0);
        repeat (60) tick();
        check("s5_no_res", res_seen, 0);
        start_run();
        done_after(40, 15, 15, 9, 9);
        wait_res(100, "s5");
        check("s5_rerun_score", res_score, 38);

        // DONE while idle is ignored; run DONE at wcnt=3
        res_seen = 1'b0;
        done_after(2, 15, 15, 15, 15);
        repeat (3) tick();
        start_run();
        done_after(43, 6, 2, 5, 5);
        wait_res(100, "s6");
        check("s6_score", res_score, 2);
        check("s6_latency", res_cyc - done_cyc, NPTS + 1);

        repeat (5) tick();
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
